// File: rtl/count_snapshot_fifo.sv
// count_snapshot_fifo: captures the upstream event counter value into a small FIFO on each trig pulse.
// Latency: a captured sample is visible on out_data one cycle after trig (no same-cycle bypass); first-word fall-through.
// Backpressure: out_valid/out_ready handshake; a trig into a full FIFO without a pop is dropped and sets sticky ovf.
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   count [W-1:0]         counter value to sample
//   trig                  capture request for this cycle
//   clr                   synchronous flush (empties FIFO, clears ovf), beats trig and pop
//   out_valid/out_ready   output handshake; out_data is the head entry (0 when empty)
//   level                 occupancy 0..DEPTH
//   ovf                   sticky: a trig was dropped since the last rst/clr
//
// Optional build macro SNAPSHOT_PROPS_EN adds embedded formal/simulation properties;
// it adds no logic to the synthesized design.

module count_snapshot_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [W-1:0]               count,
   input  logic                       trig,
   input  logic                       clr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [W-1:0]               out_data,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rptr;
   logic [AW-1:0] wptr;
   logic          pop;
   logic          push;
   logic          drop;

   assign out_valid = (level != '0);
   // Empty FIFO shows 0 so the output is defined from reset without clearing storage.
   assign out_data  = out_valid ? mem[rptr] : '0;

   assign pop  = out_valid & out_ready;
   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign push = trig & ((level < FULL) | pop);
   assign drop = trig & (level == FULL) & ~pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr  <= '0;
         wptr  <= '0;
         level <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         rptr  <= '0;
         wptr  <= '0;
         level <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         if (drop) ovf <= 1'b1;
      end
   end

   // Storage needs no reset; contents are only observed through level-qualified out_data.
   always_ff @(posedge clk) begin
      if (push && !clr) mem[wptr] <= count;
   end

`ifdef SNAPSHOT_PROPS_EN
   logic          past_vld;
   logic          prev_valid;
   logic          prev_ready;
   logic          prev_clr;
   logic          prev_drop;
   logic          prev_ovf;
   logic [W-1:0]  prev_data;

   always @(posedge clk) begin
      assume (!rst && out_ready);
      if (rst) begin
         past_vld <= 1'b0;
      end else begin
         assert (level <= FULL);
         assert (out_valid == (level != '0));
         // A flush legitimately drops a stalled head, so only non-flush cycles are held.
         if (past_vld && prev_valid && !prev_ready && !prev_clr)
            assert (out_valid && (out_data == prev_data));
         if (past_vld && ovf && !prev_ovf)
            assert (prev_drop);
         past_vld   <= 1'b1;
         prev_valid <= out_valid;
         prev_ready <= out_ready;
         prev_clr   <= clr;
         prev_drop  <= drop & ~clr;
         prev_ovf   <= ovf;
         prev_data  <= out_data;
      end
   end

   assume property (@(posedge clk) (level != '0) |-> !trig);
   assert property (@(posedge clk) (level != '0) |-> s_eventually !out_valid);
`endif

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Bench for count_snapshot_fifo: directed scenarios then random traffic, checked by a queue model.
// The model accepts/drops samples from the FIFO rules; a negedge monitor compares handshakes against it.
// Inputs change 2 time units after each rising edge; outputs are sampled on the falling edge.

module tb_count_snapshot_fifo;

   localparam int W     = 10;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH+1);

   logic          clk;
   logic          rst;
   logic [W-1:0]  count;
   logic          trig;
   logic          clr;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [LW-1:0] level;
   logic          ovf;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   int            m_level;
   logic          m_ovf;
   logic [W-1:0]  sb[$];

   count_snapshot_fifo #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .count(count), .trig(trig), .clr(clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .ovf(ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk = n_chk + 1;
      if (act == exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model: a plain queue of accepted samples plus occupancy/overflow bookkeeping.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sb.delete();
         m_level <= 0;
         m_ovf   <= 1'b0;
      end else if (clr) begin
         sb.delete();
         m_level <= 0;
         m_ovf   <= 1'b0;
      end else begin
         bit p_out;
         bit p_in;
         p_out = (m_level != 0) && out_ready;
         p_in  = trig && ((m_level < DEPTH) || p_out);
         if (p_in) sb.push_back(count);
         if (trig && !p_in) m_ovf <= 1'b1;
         m_level <= m_level + int'(p_in) - int'(p_out);
      end
   end

   // Monitor: compares status every cycle; pops the expected queue on each accepted head.
   always @(negedge clk) begin
      if (!rst) begin
         chk("level", int'(level), m_level);
         chk("out_valid", int'(out_valid), int'(m_level != 0));
         chk("ovf", int'(ovf), int'(m_ovf));
         if (out_valid) begin
            if (sb.size() == 0) begin
               n_chk = n_chk + 1;
               $display("FAIL data: out_valid with data %0d but no sample expected at %0t", out_data, $time);
            end else if (out_ready && !clr) begin
               chk("pop_data", int'(out_data), int'(sb.pop_front()));
            end else begin
               chk("hold_data", int'(out_data), int'(sb[0]));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic capture(input int v);
      count = W'(v);
      trig  = 1'b1;
      step();
      trig  = 1'b0;
   endtask

   task automatic drain(input int cycles);
      out_ready = 1'b1;
      repeat (cycles) step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; count = '0; trig = 1'b0; clr = 1'b0; out_ready = 1'b0;
      #12 rst = 1'b0;

      // reset then idle
      repeat (5) step();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_data", int'(out_data), 0);

      // single capture, held while the sink stalls
      capture(3);
      chk("single_valid", int'(out_valid), 1);
      chk("single_data", int'(out_data), 3);
      chk("single_level", int'(level), 1);
      repeat (10) step();
      chk("single_hold", int'(out_data), 3);
      drain(2);

      // fill, overflow, drain in order
      for (int i = 10; i <= 13; i++) capture(i);
      chk("full_level", int'(level), 4);
      capture(14);
      chk("drop_level", int'(level), 4);
      chk("drop_ovf", int'(ovf), 1);
      drain(6);
      chk("drain_empty", int'(level), 0);
      chk("ovf_sticky", int'(ovf), 1);

      // full FIFO with simultaneous push and pop
      clr = 1'b1; step(); clr = 1'b0;
      for (int i = 16; i <= 19; i++) capture(i);
      out_ready = 1'b1;
      capture(20);
      out_ready = 1'b0;
      chk("pushpop_level", int'(level), 4);
      chk("pushpop_ovf", int'(ovf), 0);
      drain(6);

      // counter wrap captured verbatim
      capture(1023);
      capture(0);
      drain(4);

      // clr beats a same-cycle trig
      for (int i = 30; i <= 34; i++) capture(i);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("pre_clr_level", int'(level), 3);
      chk("pre_clr_ovf", int'(ovf), 1);
      clr = 1'b1; count = W'(99); trig = 1'b1;
      step();
      clr = 1'b0; trig = 1'b0;
      chk("clr_level", int'(level), 0);
      chk("clr_valid", int'(out_valid), 0);
      chk("clr_ovf", int'(ovf), 0);

      // asynchronous reset between edges
      capture(40);
      capture(41);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_valid", int'(out_valid), 0);
      chk("arst_level", int'(level), 0);
      step();
      rst = 1'b0;

      // random traffic
      for (int c = 0; c < 500; c++) begin
         count     = W'($urandom_range(0, 1023));
         trig      = ($urandom_range(0, 99) < 55);
         out_ready = ($urandom_range(0, 99) < 45);
         clr       = ($urandom_range(0, 63) == 0);
         step();
      end
      trig = 1'b0; clr = 1'b0;
      drain(DEPTH + 2);
      chk("final_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
